multicycle_control_unit: RTL
============================

# multicycle_control_unit

Sequential, parametrised control unit for the multi-cycle CPU core. It sequences each instruction through fetch, decode, execute, memory and writeback states, and handshakes with the instruction and data memories. It drives the same datapath control fields as the single-cycle decoder, plus PC, IR and memory strobes. Unlike the single-cycle decoder, it decodes load/store access size from funct3 and traps on illegal opcodes and memory timeouts instead of defaulting to ADD.

## Interface
- `SUBWORD_EN`, default 1: 1 means LD/ST take data_size from funct3; 0 means data_size is always 000 and funct3 is ignored.
- `MEM_TIMEOUT`, default 0: maximum number of MEM-state cycles with data_ready low before a bus error; 0 disables the timeout; maximum value 65535.
- `clk`  in  1  the single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  7  instruction opcode, sampled in DECODE.
- `funct7`  in  7  instruction funct7, sampled in DECODE (reserved; no current effect).
- `funct3`  in  3  instruction funct3, sampled in DECODE.
- `instr_ready`  in  1  instruction memory has valid data this cycle.
- `data_ready`  in  1  data memory has completed the read or write this cycle.
- `trap_clear`  in  1  leave TRAP and return to FETCH.
- `alu_op`  out  4  ALU operation.
- `branch_cond`  out  3  000 beq, 001 bne, 010 none, 011 always.
- `data_read_en`, `data_write_en`  out  1 each  data memory strobes.
- `data_size`  out  3  access size.
- `mem_to_reg`  out  2  writeback source: 01 memory, 00 ALU.
- `reg_write_en`  out  1  register file write strobe.
- `alu_a_src`  out  1  0 = rs1, 1 = pc.
- `alu_b_src`  out  1  0 = rs2, 1 = ext_imm.
- `instr_read_en`  out  1  instruction fetch request.
- `ir_write_en`  out  1  IR load strobe.
- `pc_write_en`  out  1  PC update strobe.
- `illegal_instr`, `bus_error`  out  1 each  sticky trap causes.
- `state`  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.

## Operation
- **Opcode map and decoded fields** (alu_op / alu_a_src / alu_b_src):
  - LD 0000000: alu_op 0000, a=0, b=1, mem_to_reg 01.
  - ST 0000100: alu_op 0000, a=0, b=1.
  - ADD 0001000: 0000, a=0, b=0.
  - SUB 0001100: 0001, a=0, b=0.
  - INV 0010000: 0010, a=0, b=0.
  - LSL 0010100: 0011, a=0, b=0.
  - LSR 0011000: 0100, a=0, b=0.
  - AND 0011100: 0101, a=0, b=0.
  - OR 0100000: 0110, a=0, b=0.
  - SLT 0100100: 0111, a=0, b=0.
  - BEQ 0101100: 0000, a=1, b=1, branch_cond 000.
  - BNE 0110000: 0000, a=1, b=1, branch_cond 001.
  - JMP 0110100: 0000, a=1, b=1, branch_cond 011.
  - LUI 0111000: 1000, a=0, b=1.
  - All other opcodes are illegal.
- **Access size:** with SUBWORD_EN=1, an LD/ST funct3 of 000, 001, 010, 100 or 101 is copied to data_size. Any other funct3 value on LD/ST is illegal.
- **Held fields:** decoded fields (alu_op, branch_cond, mem_to_reg, srcs, data_size) are registered on the DECODE→EXEC edge and held until the next DECODE exit.
- **FETCH:** instr_read_en=1. When instr_ready=1, ir_write_en=1 in the same cycle and the next state is DECODE. Otherwise remain in FETCH.
- **DECODE:** next state is TRAP with illegal_instr set if the instruction is illegal, else EXEC.
- **EXEC:**
  - BEQ/BNE/JMP: pc_write_en=1, next state FETCH.
  - LD/ST: next state MEM.
  - All others: next state WB.
- **MEM:**
  - Hold data_read_en (LD) or data_write_en (ST) until data_ready=1.
  - On data_ready: LD goes to WB; ST pulses pc_write_en and goes to FETCH.
  - A 16-bit wait counter clears on MEM entry and increments on each cycle with data_ready low.
  - If MEM_TIMEOUT≠0 and the count reaches MEM_TIMEOUT with data_ready still low, go to TRAP and set bus_error; the strobe drops on that edge.
- **WB:** reg_write_en=1 and pc_write_en=1 for one cycle, then FETCH.
- **TRAP:**
  - All strobes are 0; illegal_instr/bus_error stay high.
  - trap_clear=1 clears both flags and returns to FETCH.
  - trap_clear in any other state is ignored.
- **Strobes:** instr_read_en, ir_write_en, data_read_en, data_write_en, reg_write_en and pc_write_en are pure functions of state plus handshake input, and are never asserted outside their state.

## Timing
- **Reset:** rst=1 at an edge sets state=FETCH, clears the wait counter and flags, and sets all outputs from that edge:
  - alu_op=0000, branch_cond=010, data_size=000, mem_to_reg=00, srcs=0.
  - All strobes 0, except instr_read_en=1 once rst is low.
- **Reset mid-operation:** a pending memory transaction is abandoned and no reg or PC write occurs.
- **Minimum latency with zero-wait memory:**
  - ALU/LUI: 4 cycles (F, D, E, W).
  - LD: 5 cycles.
  - ST: 4 cycles.
  - Branch/JMP: 3 cycles.
- **Wait cycles:** each cycle of instr_ready or data_ready low adds exactly one cycle.
- **Handshake sampling:** ready inputs are sampled only in their own state. instr_ready=1 during DECODE is ignored.
- **Timeout boundary:**
  - MEM_TIMEOUT=N traps on the edge ending the N-th consecutive low cycle.
  - data_ready=1 in that same cycle wins: normal completion, no trap.
- **Simultaneous events:** rst and trap_clear together means rst wins.

## Test plan
- **Reset:** hold rst 3 cycles, then release with instr_ready=1 and opcode ADD (0001000) → state sequence 0,1,2,4,0. Expect reg_write_en and pc_write_en high only in cycle 4, alu_op=0000, srcs 0/0.
- **Load with wait states:** LD with funct3=001, data_ready low for 3 MEM cycles → data_read_en high for 4 cycles, data_size=001, mem_to_reg=01, then WB with reg_write_en=1. Total 8 cycles.
- **Branches:** BNE then JMP with zero wait → each takes 3 cycles. branch_cond=001 then 011, alu_a_src=1, alu_b_src=1, pc_write_en pulses once in EXEC, reg_write_en never high.
- **Illegal opcode:** opcode 1111111 → TRAP with illegal_instr=1 and all strobes 0 for 10 cycles. trap_clear=1 → FETCH next cycle with illegal_instr=0. Repeat with LD funct3=011 → same trap.
- **Timeout:** MEM_TIMEOUT=4, ST with data_ready held low → data_write_en high 4 cycles, then state=5 and bus_error=1. A second run with data_ready=1 in the 4th cycle → normal completion, bus_error=0.
- **Reset mid-MEM:** rst in the 2nd cycle of an LD wait → data_read_en=0 and state=0 next cycle, and reg_write_en never asserts.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// ============================================================================
// Module   : multicycle_control_unit
// Purpose  : FETCH/DECODE/EXEC/MEM/WB/TRAP sequencer for the multi-cycle core
// Revision : 1.0
// ============================================================================
`default_nettype none

module multicycle_control_unit #(
    parameter bit          SUBWORD_EN  = 1'b1,
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [6:0] funct7,
    input  logic [2:0] funct3,
    input  logic       instr_ready,
    input  logic       data_ready,
    input  logic       trap_clear,
    output logic [3:0] alu_op,
    output logic [2:0] branch_cond,
    output logic       data_read_en,
    output logic       data_write_en,
    output logic [2:0] data_size,
    output logic [1:0] mem_to_reg,
    output logic       reg_write_en,
    output logic       alu_a_src,
    output logic       alu_b_src,
    output logic       instr_read_en,
    output logic       ir_write_en,
    output logic       pc_write_en,
    output logic       illegal_instr,
    output logic       bus_error,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [16:0] C_TIMEOUT = 17'(MEM_TIMEOUT);

    state_t      r_state;
    logic [15:0] r_wait_cnt;
    logic        r_illegal, r_bus_err;
    logic [3:0]  r_alu_op;
    logic [2:0]  r_branch_cond, r_data_size;
    logic [1:0]  r_mem_to_reg;
    logic        r_a_src, r_b_src, r_is_ld, r_is_st, r_is_br;

    logic       w_legal, w_a_src, w_b_src, w_is_ld, w_is_st, w_is_br;
    logic [3:0] w_alu_op;
    logic [2:0] w_branch_cond, w_data_size;
    logic [1:0] w_mem_to_reg;
    logic       w_timeout, w_run;
    logic       w_unused;

    // funct7 is reserved for future opcodes
    assign w_unused = ^funct7;

    always_comb begin
        w_legal       = 1'b1;
        w_alu_op      = 4'd0;
        w_branch_cond = 3'b010;
        w_mem_to_reg  = 2'b00;
        w_a_src       = 1'b0;
        w_b_src       = 1'b0;
        w_data_size   = 3'b000;
        w_is_ld       = 1'b0;
        w_is_st       = 1'b0;
        w_is_br       = 1'b0;
        case (opcode)
            7'b0000000: begin w_is_ld = 1'b1; w_b_src = 1'b1; w_mem_to_reg = 2'b01; end
            7'b0000100: begin w_is_st = 1'b1; w_b_src = 1'b1; end
            7'b0001000: w_alu_op = 4'd0;
            7'b0001100: w_alu_op = 4'd1;
            7'b0010000: w_alu_op = 4'd2;
            7'b0010100: w_alu_op = 4'd3;
            7'b0011000: w_alu_op = 4'd4;
            7'b0011100: w_alu_op = 4'd5;
            7'b0100000: w_alu_op = 4'd6;
            7'b0100100: w_alu_op = 4'd7;
            7'b0101100: begin w_is_br = 1'b1; w_a_src = 1'b1; w_b_src = 1'b1; w_branch_cond = 3'b000; end
            7'b0110000: begin w_is_br = 1'b1; w_a_src = 1'b1; w_b_src = 1'b1; w_branch_cond = 3'b001; end
            7'b0110100: begin w_is_br = 1'b1; w_a_src = 1'b1; w_b_src = 1'b1; w_branch_cond = 3'b011; end
            7'b0111000: begin w_alu_op = 4'd8; w_b_src = 1'b1; end
            default:    w_legal = 1'b0;
        endcase
        if ((w_is_ld || w_is_st) && SUBWORD_EN) begin
            if (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                w_data_size = funct3;
            else
                w_legal = 1'b0;
        end
    end

    // Trap on the edge that ends the N-th consecutive low cycle; data_ready wins
    assign w_timeout = (C_TIMEOUT != 17'd0) && !data_ready
                    && ((17'(r_wait_cnt) + 17'd1) == C_TIMEOUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_FETCH;
            r_wait_cnt    <= 16'd0;
            r_illegal     <= 1'b0;
            r_bus_err     <= 1'b0;
            r_alu_op      <= 4'd0;
            r_branch_cond <= 3'b010;
            r_data_size   <= 3'b000;
            r_mem_to_reg  <= 2'b00;
            r_a_src       <= 1'b0;
            r_b_src       <= 1'b0;
            r_is_ld       <= 1'b0;
            r_is_st       <= 1'b0;
            r_is_br       <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: if (instr_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    if (!w_legal) begin
                        r_state   <= S_TRAP;
                        r_illegal <= 1'b1;
                    end else begin
                        r_state       <= S_EXEC;
                        r_alu_op      <= w_alu_op;
                        r_branch_cond <= w_branch_cond;
                        r_data_size   <= w_data_size;
                        r_mem_to_reg  <= w_mem_to_reg;
                        r_a_src       <= w_a_src;
                        r_b_src       <= w_b_src;
                        r_is_ld       <= w_is_ld;
                        r_is_st       <= w_is_st;
                        r_is_br       <= w_is_br;
                    end
                end
                S_EXEC: begin
                    r_wait_cnt <= 16'd0;
                    if (r_is_br)                 r_state <= S_FETCH;
                    else if (r_is_ld || r_is_st) r_state <= S_MEM;
                    else                         r_state <= S_WB;
                end
                S_MEM: begin
                    if (data_ready) begin
                        r_state <= r_is_ld ? S_WB : S_FETCH;
                    end else if (w_timeout) begin
                        r_state   <= S_TRAP;
                        r_bus_err <= 1'b1;
                    end else if (r_wait_cnt != 16'hFFFF) begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
                end
                S_WB: r_state <= S_FETCH;
                S_TRAP: begin
                    if (trap_clear) begin
                        r_state   <= S_FETCH;
                        r_illegal <= 1'b0;
                        r_bus_err <= 1'b0;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Strobes are suppressed while rst is high so a reset never commits a write
    assign w_run         = !rst;
    assign instr_read_en = w_run && (r_state == S_FETCH);
    assign ir_write_en   = instr_read_en && instr_ready;
    assign data_read_en  = w_run && (r_state == S_MEM) && r_is_ld;
    assign data_write_en = w_run && (r_state == S_MEM) && r_is_st;
    assign reg_write_en  = w_run && (r_state == S_WB);
    assign pc_write_en   = w_run && (((r_state == S_EXEC) && r_is_br)
                                  || (r_state == S_WB)
                                  || ((r_state == S_MEM) && r_is_st && data_ready));

    assign alu_op        = r_alu_op;
    assign branch_cond   = r_branch_cond;
    assign data_size     = r_data_size;
    assign mem_to_reg    = r_mem_to_reg;
    assign alu_a_src     = r_a_src;
    assign alu_b_src     = r_b_src;
    assign illegal_instr = r_illegal;
    assign bus_error     = r_bus_err;
    assign state         = r_state;

endmodule

`default_nettype wire
